// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: core status codes,
// receiver FSM states and active-low seven-segment patterns.
package calc_pkg;

   localparam logic [1:0] ST_ERRO    = 2'b00;
   localparam logic [1:0] ST_OCUPADO = 2'b01;
   localparam logic [1:0] ST_PRONTO  = 2'b10;

   localparam int NUM_DIGITS = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_ERRO    = 2'd2
   } rx_state_e;

   // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_O     = 7'h23;

   function automatic logic [6:0] erro_seg(input logic [2:0] idx);
      logic [6:0] res;
      case (idx)
         3'd0:    res = SEG_O;
         3'd1:    res = SEG_R;
         3'd2:    res = SEG_R;
         3'd3:    res = SEG_E;
         default: res = SEG_BLANK;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; codes 10..15 and the
// blank flag both produce a dark digit.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/display_receiver.sv
// Captures the core's digit stream into a shadow frame, commits it atomically
// on "pronto", and scans the committed frame onto a multiplexed display.
module display_receiver
   import calc_pkg::*;
#(
   parameter int REFRESH_DIV   = 50000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] data,
   input  logic [3:0] pos,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_valid,
   output logic [1:0] dbg_state
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   rx_state_e        state_q, state_d;
   logic [3:0]       shadow_q [NUM_DIGITS];
   logic [3:0]       shadow_d [NUM_DIGITS];
   logic [3:0]       disp_q   [NUM_DIGITS];
   logic [3:0]       disp_d   [NUM_DIGITS];
   logic             fv_q, fv_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       st;
   logic [NUM_DIGITS-1:0] lead_zero;
   logic             above_zero;
   logic [3:0]       mux_digit;
   logic             mux_blank;
   logic [6:0]       dec_seg;

   // Reserved status 11 behaves as "ocupado".
   assign st = (status == 2'b11) ? ST_OCUPADO : status;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (st == ST_OCUPADO)   state_d = S_CAPTURE;
            else if (st == ST_ERRO) state_d = S_ERRO;
         end
         S_CAPTURE: begin
            if (st == ST_PRONTO)    state_d = S_IDLE;
            else if (st == ST_ERRO) state_d = S_ERRO;
         end
         default: state_d = S_ERRO;
      endcase
   end

   always_comb begin
      shadow_d = shadow_q;
      disp_d   = disp_q;
      fv_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (st == ST_OCUPADO) begin
               for (int i = 0; i < NUM_DIGITS; i++) shadow_d[i] = 4'd0;
            end
         end
         S_CAPTURE: begin
            if (st == ST_OCUPADO && !pos[3]) begin
               shadow_d[pos[2:0]] = data;
            end else if (st == ST_PRONTO) begin
               disp_d = shadow_q;
               fv_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_q[i] <= 4'd0;
            disp_q[i]   <= 4'd0;
         end
         fv_q  <= 1'b0;
         div_q <= '0;
         idx_q <= 3'd0;
         an_q  <= 8'hFF;
         seg_q <= SEG_BLANK;
      end else begin
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         fv_q     <= fv_d;
         div_q    <= div_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   always_comb begin
      div_d = div_q + 1'b1;
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = idx_q + 3'd1;
      end
   end

   // lead_zero[i] is set when digit i and every digit above it are zero.
   always_comb begin
      lead_zero  = '0;
      above_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         above_zero   = above_zero && (disp_q[i] == 4'd0);
         lead_zero[i] = above_zero;
      end
   end

   assign mux_digit = disp_q[idx_q];
   assign mux_blank = BLANK_LEADING && (idx_q != 3'd0) && lead_zero[idx_q];

   seg7_decoder u_dec (
      .bcd   (mux_digit),
      .blank (mux_blank),
      .seg   (dec_seg)
   );

   // an and seg come from the same idx_q so they always change together.
   always_comb begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = (state_q == S_ERRO) ? erro_seg(idx_q) : dec_seg;
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = 1'b1;
   assign frame_valid = fv_q;
   assign dbg_state   = state_q;

endmodule
